dma_ch_arbiter: RTL and testbench



---
 rtl/dma_ch_arbiter_pkg.sv | 11 +
 rtl/dma_ch_arbiter_if.sv | 31 +++
 rtl/dma_rr_pick.sv | 30 +++
 rtl/dma_ch_arbiter.sv | 144 ++++++++++++++
 tb/tb_dma_ch_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_ch_arbiter_pkg.sv
// Shared types for the DMA channel scheduler.
package dma_ch_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_START   = 2'd1,
        ARB_BUSY    = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/dma_ch_arbiter_if.sv
// Channel-controller / engine bundle seen by the DMA channel scheduler.
interface dma_ch_arbiter_if #(
    parameter int NUM_CH = 4
);
    localparam int ID_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0] ch_req;
    logic [NUM_CH-1:0] ch_hipri;
    logic [NUM_CH-1:0] ch_abort;
    logic              xfer_done;
    logic              xfer_start;
    logic              abort;
    logic [NUM_CH-1:0] grant_oh;
    logic [ID_W-1:0]   grant_id;
    logic              busy;
    logic [NUM_CH-1:0] ch_done;
    logic [NUM_CH-1:0] ch_aborted;

    // Scheduler side
    modport slave (
        input  ch_req, ch_hipri, ch_abort, xfer_done,
        output xfer_start, abort, grant_oh, grant_id, busy, ch_done, ch_aborted
    );

    // Channel controllers + engine side
    modport master (
        output ch_req, ch_hipri, ch_abort, xfer_done,
        input  xfer_start, abort, grant_oh, grant_id, busy, ch_done, ch_aborted
    );

endinterface

// File: rtl/dma_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr.
module dma_rr_pick #(
    parameter int NUM_CH = 4,
    parameter int ID_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [ID_W-1:0]   ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic              any
);
    logic [ID_W-1:0] idx;
    logic            found;

    // NUM_CH is a power of two, so the ID_W-bit add wraps modulo NUM_CH
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = ptr + ID_W'(k);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/dma_ch_arbiter.sv
// DMA channel scheduler: grants the shared read/write engine to one channel
// at a time (high class first, round-robin per class, starvation promotion).
module dma_ch_arbiter
    import dma_ch_arbiter_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int STARVE_MAX = 4
) (
    input logic             hclk,
    input logic             hreset,
    dma_ch_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] SMAX = CNT_W'(STARVE_MAX);

    arb_state_e state, next_state;

    logic [NUM_CH-1:0]            elig, promo, hi_set, lo_set;
    logic [NUM_CH-1:0]            hi_gnt, lo_gnt, win_oh;
    logic                         hi_any, lo_any;
    logic [ID_W-1:0]              win_id, rr_hi, rr_lo;
    logic [NUM_CH-1:0][CNT_W-1:0] starve;
    logic                         win_lo_q, abt_flag, own_abort, arb_now;

    logic [NUM_CH-1:0] grant_oh_q, ch_done_q, ch_aborted_q;
    logic [NUM_CH-1:0] done_d, aborted_d;
    logic [ID_W-1:0]   grant_id_q;
    logic              xfer_start_q, busy_q, start_d, busy_d, abort_c;

    assign elig      = bus.ch_req & ~bus.ch_abort;
    assign arb_now   = (state == ARB_IDLE) && (|elig);
    assign own_abort = bus.ch_abort[grant_id_q];

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) promo[i] = (starve[i] == SMAX);
    end

    // Promoted low channels compete in the high set but keep their low pointer
    assign hi_set = elig & (bus.ch_hipri | promo);
    assign lo_set = elig & ~bus.ch_hipri & ~promo;

    dma_rr_pick #(.NUM_CH(NUM_CH)) u_pick_hi (
        .req(hi_set), .ptr(rr_hi), .gnt(hi_gnt), .any(hi_any)
    );
    dma_rr_pick #(.NUM_CH(NUM_CH)) u_pick_lo (
        .req(lo_set), .ptr(rr_lo), .gnt(lo_gnt), .any(lo_any)
    );

    assign win_oh = hi_any ? hi_gnt : (lo_any ? lo_gnt : '0);

    always_comb begin
        win_id = '0;
        for (int i = 0; i < NUM_CH; i++) if (win_oh[i]) win_id = ID_W'(i);
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) state <= ARB_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE:    if (|elig) next_state = ARB_START;
            ARB_START:   next_state = ARB_BUSY;
            ARB_BUSY:    if (bus.xfer_done) next_state = ARB_RELEASE;
            ARB_RELEASE: next_state = ARB_IDLE;
            default:     next_state = ARB_IDLE;
        endcase
    end

    // Next values for the registered outputs; abort alone stays combinational
    always_comb begin
        abort_c   = (state == ARB_BUSY) && (abt_flag || own_abort);
        start_d   = arb_now;
        busy_d    = (next_state != ARB_IDLE);
        done_d    = '0;
        aborted_d = '0;
        if (state == ARB_BUSY && bus.xfer_done) begin
            if (abt_flag || own_abort) aborted_d = grant_oh_q;
            else                       done_d    = grant_oh_q;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            xfer_start_q <= 1'b0;
            busy_q       <= 1'b0;
            ch_done_q    <= '0;
            ch_aborted_q <= '0;
            grant_oh_q   <= '0;
            grant_id_q   <= '0;
            win_lo_q     <= 1'b0;
            abt_flag     <= 1'b0;
            rr_hi        <= '0;
            rr_lo        <= '0;
        end else begin
            xfer_start_q <= start_d;
            busy_q       <= busy_d;
            ch_done_q    <= done_d;
            ch_aborted_q <= aborted_d;
            case (state)
                ARB_IDLE: if (arb_now) begin
                    grant_oh_q <= win_oh;
                    grant_id_q <= win_id;
                    win_lo_q   <= ~|(win_oh & bus.ch_hipri);
                    abt_flag   <= 1'b0;
                end
                ARB_START, ARB_BUSY: if (own_abort) abt_flag <= 1'b1;
                ARB_RELEASE: begin
                    if (win_lo_q) rr_lo <= grant_id_q + ID_W'(1);
                    else          rr_hi <= grant_id_q + ID_W'(1);
                    grant_oh_q <= '0;
                    grant_id_q <= '0;
                    abt_flag   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            starve <= '0;
        end else if (arb_now) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (win_oh[i] || !elig[i])
                    starve[i] <= '0;
                else if (!bus.ch_hipri[i] && starve[i] != SMAX)
                    starve[i] <= starve[i] + CNT_W'(1);
            end
        end
    end

    assign bus.xfer_start = xfer_start_q;
    assign bus.abort      = abort_c;
    assign bus.grant_oh   = grant_oh_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.busy       = busy_q;
    assign bus.ch_done    = ch_done_q;
    assign bus.ch_aborted = ch_aborted_q;

endmodule

// File: tb/tb_dma_ch_arbiter.sv
// Bench for dma_ch_arbiter: directed scenarios plus randomized transactions
// against a transaction-level scheduling model.
module tb_dma_ch_arbiter;
    localparam int N    = 4;
    localparam int SMAX = 4;

    logic hclk = 1'b0;
    logic hreset;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    int m_rr_hi, m_rr_lo;
    int m_cnt [N];

    dma_ch_arbiter_if #(.NUM_CH(N)) bus ();

    dma_ch_arbiter #(.NUM_CH(N), .STARVE_MAX(SMAX)) dut (
        .hclk(hclk), .hreset(hreset), .bus(bus)
    );

    always #5 hclk = ~hclk;
    always @(posedge hclk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic do_reset();
        hreset = 1'b1;
        bus.ch_req = '0; bus.ch_hipri = '0; bus.ch_abort = '0; bus.xfer_done = 1'b0;
        step(); step();
        hreset = 1'b0;
        m_rr_hi = 0; m_rr_lo = 0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        step();
    endtask

    // Called in the START cycle; leaves the bench in the RELEASE cycle
    task automatic finish_xfer(input int d);
        repeat (d) step();
        bus.xfer_done = 1'b1;
        step();
        bus.xfer_done = 1'b0;
    endtask

    // Scheduling rules: high or promoted first, else low; first at/after pointer
    function automatic int model_pick(input logic [N-1:0] el, input logic [N-1:0] hi);
        logic [N-1:0] cand;
        int ptr;
        cand = '0;
        for (int i = 0; i < N; i++) if (el[i] && (hi[i] || m_cnt[i] == SMAX)) cand[i] = 1'b1;
        if (cand != '0) ptr = m_rr_hi;
        else begin cand = el; ptr = m_rr_lo; end
        for (int k = 0; k < N; k++) if (cand[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic model_arb(input logic [N-1:0] el, input logic [N-1:0] hi, input int w);
        for (int i = 0; i < N; i++) begin
            if (i == w || !el[i]) m_cnt[i] = 0;
            else if (!hi[i] && m_cnt[i] < SMAX) m_cnt[i] = m_cnt[i] + 1;
        end
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        bus.ch_req = 4'b1111; bus.ch_hipri = '0; bus.ch_abort = '0; bus.xfer_done = 1'b0;
        step(); step();
        checks++;
        if ({bus.busy, bus.xfer_start, bus.abort, bus.grant_oh, bus.grant_id, bus.ch_done, bus.ch_aborted} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%0b start=%0b oh=%b id=%0d expected all 0",
                     bus.busy, bus.xfer_start, bus.grant_oh, bus.grant_id);
        end
        bus.ch_req = '0;
    endtask

    task automatic test_single_low();
        do_reset();
        bus.ch_req = 4'b0100;
        step();
        checks++;
        if ({bus.xfer_start, bus.busy, bus.grant_oh, bus.grant_id} !== {1'b1, 1'b1, 4'b0100, 2'd2}) begin
            errors++;
            $display("FAIL single_grant: got start=%0b busy=%0b oh=%b id=%0d expected 1 1 0100 2",
                     bus.xfer_start, bus.busy, bus.grant_oh, bus.grant_id);
        end
        step();
        checks++;
        if (bus.xfer_start !== 1'b0) begin
            errors++; $display("FAIL single_start_len: got %0b expected 0", bus.xfer_start);
        end
        bus.xfer_done = 1'b1;
        step();
        bus.xfer_done = 1'b0; bus.ch_req = '0;
        checks++;
        if ({bus.ch_done, bus.ch_aborted, bus.busy, bus.grant_oh} !== {4'b0100, 4'b0000, 1'b1, 4'b0100}) begin
            errors++;
            $display("FAIL single_done: got done=%b aborted=%b busy=%0b oh=%b expected 0100 0000 1 0100",
                     bus.ch_done, bus.ch_aborted, bus.busy, bus.grant_oh);
        end
        step();
        checks++;
        if ({bus.busy, bus.grant_oh, bus.grant_id, bus.ch_done} !== '0) begin
            errors++;
            $display("FAIL single_idle: got busy=%0b oh=%b id=%0d done=%b expected 0",
                     bus.busy, bus.grant_oh, bus.grant_id, bus.ch_done);
        end
        bus.ch_req = 4'b1001;
        step();
        checks++;
        if (bus.grant_id !== 2'd3) begin
            errors++; $display("FAIL single_rr_lo: got id=%0d expected 3", bus.grant_id);
        end
    endtask

    task automatic test_rr_all_low();
        int last;
        do_reset();
        bus.ch_req = 4'b1111;
        last = 0;
        for (int g = 0; g < 5; g++) begin
            for (int t = 0; t < 20 && bus.xfer_start !== 1'b1; t++) step();
            checks++;
            if (bus.xfer_start !== 1'b1) begin
                errors++; $display("FAIL rr_start_timeout: got start=%0b expected 1", bus.xfer_start);
            end
            checks++;
            if (bus.grant_id !== 2'(g % N)) begin
                errors++; $display("FAIL rr_order: got id=%0d expected %0d", bus.grant_id, g % N);
            end
            if (g > 0) begin
                checks++;
                if (cyc - last !== 6) begin
                    errors++; $display("FAIL rr_spacing: got %0d cycles expected 6", cyc - last);
                end
            end
            last = cyc;
            finish_xfer(3);
        end
        bus.ch_req = '0;
    endtask

    task automatic test_starvation();
        int exp_seq [6] = '{0, 0, 0, 0, 1, 0};
        do_reset();
        bus.ch_req = 4'b0011; bus.ch_hipri = 4'b0001;
        for (int g = 0; g < 6; g++) begin
            for (int t = 0; t < 20 && bus.xfer_start !== 1'b1; t++) step();
            checks++;
            if (bus.xfer_start !== 1'b1 || bus.grant_id !== 2'(exp_seq[g])) begin
                errors++;
                $display("FAIL starve_order: arb %0d got start=%0b id=%0d expected 1 %0d",
                         g, bus.xfer_start, bus.grant_id, exp_seq[g]);
            end
            finish_xfer(1);
        end
        bus.ch_req = '0; bus.ch_hipri = '0;
    endtask

    task automatic test_owner_abort();
        do_reset();
        bus.ch_req = 4'b0010;
        step();
        step();
        checks++;
        if (bus.abort !== 1'b0) begin
            errors++; $display("FAIL abort_before: got %0b expected 0", bus.abort);
        end
        step();
        bus.ch_abort = 4'b0010;
        #1;
        checks++;
        if (bus.abort !== 1'b1) begin
            errors++; $display("FAIL abort_comb: got %0b expected 1", bus.abort);
        end
        step();
        bus.ch_abort = '0;
        #1;
        checks++;
        if (bus.abort !== 1'b1) begin
            errors++; $display("FAIL abort_held: got %0b expected 1", bus.abort);
        end
        bus.xfer_done = 1'b1;
        step();
        bus.xfer_done = 1'b0; bus.ch_req = '0;
        checks++;
        if ({bus.ch_aborted, bus.ch_done, bus.abort} !== {4'b0010, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL abort_result: got aborted=%b done=%b abort=%0b expected 0010 0000 0",
                     bus.ch_aborted, bus.ch_done, bus.abort);
        end
        // abort arriving together with xfer_done still counts as aborted
        do_reset();
        bus.ch_req = 4'b0001;
        step(); step();
        bus.ch_abort = 4'b0001; bus.xfer_done = 1'b1;
        step();
        bus.ch_abort = '0; bus.xfer_done = 1'b0; bus.ch_req = '0;
        checks++;
        if ({bus.ch_aborted, bus.ch_done} !== {4'b0001, 4'b0000}) begin
            errors++;
            $display("FAIL abort_with_done: got aborted=%b done=%b expected 0001 0000",
                     bus.ch_aborted, bus.ch_done);
        end
    endtask

    task automatic test_nonowner_abort();
        do_reset();
        bus.ch_req = 4'b1000; bus.ch_abort = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({bus.busy, bus.xfer_start, bus.grant_oh} !== '0) begin
                errors++;
                $display("FAIL blocked_idle: got busy=%0b start=%0b oh=%b expected 0",
                         bus.busy, bus.xfer_start, bus.grant_oh);
            end
        end
        bus.ch_abort = '0;
        step();
        checks++;
        if ({bus.xfer_start, bus.busy, bus.grant_id} !== {1'b1, 1'b1, 2'd3}) begin
            errors++;
            $display("FAIL unblocked_grant: got start=%0b busy=%0b id=%0d expected 1 1 3",
                     bus.xfer_start, bus.busy, bus.grant_id);
        end
        bus.ch_req = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.ch_req = 4'b0001;
        step();
        finish_xfer(1);
        bus.ch_req = '0;
        step();
        bus.ch_req = 4'b0010;
        step(); step();
        bus.ch_abort = 4'b0010;
        #1;
        hreset = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.xfer_start, bus.abort, bus.grant_oh, bus.grant_id, bus.ch_done, bus.ch_aborted} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%0b abort=%0b oh=%b id=%0d expected all 0",
                     bus.busy, bus.abort, bus.grant_oh, bus.grant_id);
        end
        bus.ch_abort = '0; bus.ch_req = '0;
        step();
        hreset = 1'b0;
        bus.ch_req = 4'b0011;
        step();
        checks++;
        if ({bus.xfer_start, bus.grant_id} !== {1'b1, 2'd0}) begin
            errors++;
            $display("FAIL reset_ptr: got start=%0b id=%0d expected 1 0", bus.xfer_start, bus.grant_id);
        end
        bus.ch_req = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] req, hi, ab, el, oh, noise;
        int w, mode, d;
        logic exp_abort;
        do_reset();
        for (int t = 0; t < 60; t++) begin
            req = 4'($urandom); hi = 4'($urandom); ab = 4'($urandom & $urandom);
            el  = req & ~ab;
            bus.ch_req = req; bus.ch_hipri = hi; bus.ch_abort = ab;
            if (el == '0) begin
                step(); step();
                checks++;
                if (bus.busy !== 1'b0) begin
                    errors++; $display("FAIL rand_no_elig: got busy=%0b expected 0", bus.busy);
                end
                bus.ch_req = '0; bus.ch_abort = '0;
                continue;
            end
            w  = model_pick(el, hi);
            model_arb(el, hi, w);
            oh = 4'b0001 << w;
            step();
            checks++;
            if ({bus.xfer_start, bus.busy, bus.grant_id, bus.grant_oh} !== {1'b1, 1'b1, 2'(w), oh}) begin
                errors++;
                $display("FAIL rand_grant: txn %0d got start=%0b id=%0d oh=%b expected 1 %0d %b",
                         t, bus.xfer_start, bus.grant_id, bus.grant_oh, w, oh);
            end
            mode = $urandom_range(0, 2);
            d    = $urandom_range(1, 4);
            bus.ch_abort = '0; bus.ch_req = 4'($urandom); bus.ch_hipri = 4'($urandom);
            step();
            for (int k = 1; k <= d; k++) begin
                noise = 4'($urandom) & ~oh;
                bus.ch_abort = noise | ((mode == 1 && k == 1) ? oh : '0);
                if (k == d) begin
                    bus.xfer_done = 1'b1;
                    if (mode == 2) bus.ch_abort = noise | oh;
                end
                #1;
                exp_abort = (mode == 1) || (mode == 2 && k == d);
                checks++;
                if (bus.abort !== exp_abort) begin
                    errors++;
                    $display("FAIL rand_abort: txn %0d cyc %0d got %0b expected %0b", t, k, bus.abort, exp_abort);
                end
                step();
            end
            bus.xfer_done = 1'b0; bus.ch_req = '0; bus.ch_abort = '0;
            checks++;
            if ({bus.ch_done, bus.ch_aborted} !== ((mode != 0) ? {4'b0000, oh} : {oh, 4'b0000})) begin
                errors++;
                $display("FAIL rand_complete: txn %0d got done=%b aborted=%b mode=%0d owner=%0d",
                         t, bus.ch_done, bus.ch_aborted, mode, w);
            end
            if (hi[w]) m_rr_hi = (w + 1) % N;
            else       m_rr_lo = (w + 1) % N;
            step();
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++; $display("FAIL rand_release: txn %0d got busy=%0b expected 0", t, bus.busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_low();
        test_rr_all_low();
        test_starvation();
        test_owner_abort();
        test_nonowner_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
